// File: rtl/ram_responder.sv
// ram_responder: RAM-side responder with pipelined reads, streaming preload and dump.
// Define RAM_RESP_STATS_EN to add the rd_cnt/wr_cnt access counters.
module ram_responder #(
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1,
    parameter int AW     = 18,
    parameter int DW     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RAM_OE,
    input  logic          RAM_WE,
    input  logic [AW-1:0] RAM_A,
    input  logic [DW-1:0] RAM_D,
    output logic [DW-1:0] RAM_Q,
    output logic          RAM_QV,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          dump_start,
    output logic          dump_valid,
    output logic [DW-1:0] dump_data,
    input  logic          dump_ready,
    output logic          busy,
    output logic          err
`ifdef RAM_RESP_STATS_EN
    ,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt
`endif
);
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {SERVE, LOAD, DUMP} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [RD_LAT-1:0] pv;
    logic [DW-1:0] pd [RD_LAT];
    logic          in_range, acc, issue, last, serve_wr, load_wr, we;
    logic [CW-1:0] a, waddr;
    logic [DW-1:0] wdata;

    always_comb begin
        in_range = RAM_A < AW'(DEPTH);
        a        = RAM_A[CW-1:0];
        acc      = RAM_OE || RAM_WE;
        issue    = state == SERVE && RAM_OE && !RAM_WE;
        last     = cnt == CW'(DEPTH - 1);
        serve_wr = state == SERVE && RAM_WE && in_range;
        load_wr  = state == LOAD && load_valid && !load_start;
        we       = !rst && (serve_wr || load_wr);
        waddr    = serve_wr ? a : cnt;
        wdata    = serve_wr ? RAM_D : load_data;
    end

    assign RAM_Q  = pd[RD_LAT-1];
    assign RAM_QV = pv[RD_LAT-1];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Data stages only advance behind a valid token, so RAM_Q holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SERVE;
            cnt        <= '0;
            pv         <= '0;
            for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
            load_ready <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pv[0] <= issue;
            if (issue) pd[0] <= in_range ? mem[a] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
            if (acc && (state != SERVE || !in_range)) err <= 1'b1;
            case (state)
                SERVE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else if (dump_start) begin
                        state      <= DUMP;
                        cnt        <= '0;
                        dump_data  <= mem['0];
                        dump_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) cnt <= '0;
                    else if (load_valid) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state      <= SERVE;
                            load_ready <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                end
                DUMP: begin
                    if (dump_valid && dump_ready) begin
                        if (last) begin
                            state      <= SERVE;
                            dump_valid <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            dump_data <= mem[cnt + 1'b1];
                        end
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

`ifdef RAM_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (issue && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            if (serve_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the accelerator's single-port RAM interface (OE/WE/A/D/Q, 18-bit address, 24-bit data).
- One instance backs each of the IF, W and RESULT memories.
- Serves accelerator reads and writes with a configurable read latency.
- Provides a streaming preload port for filling memory before a run, and a streaming dump port for reading results back out after it.

Parameters:
- DEPTH, 4096: number of 24-bit words implemented; valid addresses are 0..DEPTH-1.
- RD_LAT, 1: read latency in cycles from the OE sample to valid RAM_Q; legal range 1..4.
- AW, 18: address width of the accelerator interface.
- DW, 24: data width.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- RAM_OE  input  1  read enable from the accelerator.
- RAM_WE  input  1  write enable from the accelerator.
- RAM_A  input  AW  access address.
- RAM_D  input  DW  write data.
- RAM_Q  output  DW  read data.
- RAM_QV  output  1  read data valid, one-cycle pulse aligned with RAM_Q.
- load_start  input  1  pulse: enter LOAD at address 0.
- load_valid  input  1  preload word valid.
- load_data  input  DW  preload word.
- load_ready  output  1  preload word accepted this cycle.
- dump_start  input  1  pulse: enter DUMP at address 0.
- dump_valid  output  1  dump word valid.
- dump_data  output  DW  dump word.
- dump_ready  input  1  consumer accepts the dump word.
- busy  output  1  high in LOAD or DUMP.
- err  output  1  sticky: out-of-range access, or an accelerator access during LOAD/DUMP.

Behaviour:
- Reset values:
  - RAM_Q=0, RAM_QV=0, load_ready=0, dump_valid=0, dump_data=0, busy=0, err=0.
  - State=SERVE, address counter=0, read pipeline cleared.
  - Memory contents are not cleared.
- Reset has priority over all inputs. A reset mid-LOAD or mid-DUMP aborts the operation, flushes in-flight reads (no RAM_QV pulse), and returns to SERVE.
- States: SERVE, LOAD, DUMP.
- SERVE:
  - RAM_WE=1 with RAM_A<DEPTH: mem[RAM_A]<=RAM_D at this edge.
  - RAM_OE=1 (and RAM_WE=0) with RAM_A<DEPTH: RAM_Q=mem[RAM_A] and RAM_QV=1 exactly RD_LAT cycles later.
  - Reads are fully pipelined: one read per cycle is accepted back-to-back.
  - A read issued the cycle after a write to the same address returns the new data.
  - RAM_OE=1 and RAM_WE=1 together: the write is performed, no read is issued, no RAM_QV.
  - RAM_A>=DEPTH: writes are dropped; reads return 0 with RAM_QV=1 after RD_LAT; err is set.
  - RAM_Q holds its last value when RAM_QV=0.
  - load_start takes priority over dump_start; both are ignored outside SERVE.
- LOAD:
  - load_ready=1 in every LOAD cycle.
  - On load_valid: mem[cnt]<=load_data, cnt++.
  - After the word at cnt=DEPTH-1 is accepted, return to SERVE; load_ready=0 from the next cycle.
  - A new load_start during LOAD restarts the load at cnt=0.
- DUMP:
  - Standard valid/ready handshake. dump_data=mem[cnt] is presented registered.
  - dump_valid rises 1 cycle after entry.
  - dump_data and dump_valid hold stable while dump_ready=0.
  - On dump_valid&&dump_ready: cnt++, next word presented the following cycle, giving 1 word/cycle throughput under constant ready.
  - After word DEPTH-1 is accepted: dump_valid=0 and return to SERVE.
- LOAD and DUMP:
  - busy=1.
  - Any RAM_OE or RAM_WE is ignored (no memory change, no RAM_QV) and sets err.
  - Reads already in flight from SERVE still complete and pulse RAM_QV on schedule.
- err clears only on rst.

Optional Feature:
- Macro: RAM_RESP_STATS_EN.
- With it defined, add outputs:
  - rd_cnt[31:0]: accepted SERVE reads, in-range and out-of-range.
  - wr_cnt[31:0]: performed in-range SERVE writes.
  - Both reset to 0 and saturate at 32'hFFFFFFFF; preload and dump traffic is excluded.
- Without it, the counters and ports do not exist.

Test Plan:
- Preload: rst, then load_start and DEPTH words data=addr*3 with load_valid held high → load_ready high for DEPTH cycles, busy falls the cycle after the last word, err=0.
- Read latency, RD_LAT=3: reads at A=0,1,2 on consecutive cycles → RAM_QV on cycles 3,4,5 with RAM_Q=0,3,6.
- Write-then-read: WE at A=5 with D=24'hABCDEF, OE at A=5 the next cycle → RAM_Q=24'hABCDEF after RD_LAT.
- Simultaneous OE and WE at A=7 with D=24'h000111 → mem[7]=24'h000111 and no RAM_QV.
- Out of range: OE at A=18'h3FFFF → RAM_Q=0, RAM_QV=1 after RD_LAT, err=1 and remains set.
- Dump with backpressure: dump_start, dump_ready toggling 1,0,0,1 → dump_data holds across stalls, all DEPTH words in address order, busy=0 after the last.
- Reset mid-dump: assert rst on word 10 → state SERVE next cycle, dump_valid=0, busy=0.
